// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing one classic (non-pipelined) Wishbone slave
// between NUM_MASTERS masters. The grant is registered and held for the whole
// bus cycle, so block and read-modify-write cycles stay atomic. An optional
// watchdog aborts a strobe the slave never acknowledges: the owner gets a
// one-cycle err pulse.
module wb_arbiter #(
  parameter int NUM_MASTERS = 4,
  parameter int ADR_WIDTH   = 32,
  parameter int DAT_WIDTH   = 32,
  parameter int SEL_WIDTH   = DAT_WIDTH / 8,
  parameter int TIMEOUT     = 0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MASTERS-1:0]           m_cyc,
  input  logic [NUM_MASTERS-1:0]           m_stb,
  input  logic [NUM_MASTERS-1:0]           m_we,
  input  logic [NUM_MASTERS*ADR_WIDTH-1:0] m_adr,
  input  logic [NUM_MASTERS*DAT_WIDTH-1:0] m_dat_m,
  input  logic [NUM_MASTERS*SEL_WIDTH-1:0] m_sel,
  output logic [NUM_MASTERS-1:0]           m_ack,
  output logic [NUM_MASTERS-1:0]           m_err,
  output logic [DAT_WIDTH-1:0]             m_dat_s,
  output logic                             s_cyc,
  output logic                             s_stb,
  output logic                             s_we,
  output logic [ADR_WIDTH-1:0]             s_adr,
  output logic [DAT_WIDTH-1:0]             s_dat_m,
  output logic [SEL_WIDTH-1:0]             s_sel,
  input  logic                             s_ack,
  input  logic [DAT_WIDTH-1:0]             s_dat_s,
  output logic [NUM_MASTERS-1:0]           gnt
);

  localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam bit WD_ON = (TIMEOUT > 0);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_MASTERS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [1:0]             state_r;
  logic [1:0]             state_nxt_s;
  logic [NUM_MASTERS-1:0] gnt_r;
  logic [NUM_MASTERS-1:0] gnt_nxt_s;
  logic [IDX_W-1:0]       owner_r;
  logic [IDX_W-1:0]       owner_nxt_s;
  logic [IDX_W-1:0]       last_r;
  logic [IDX_W-1:0]       last_nxt_s;
  logic [CNT_W-1:0]       wd_cnt_r;
  logic [CNT_W-1:0]       wd_cnt_nxt_s;
  logic                   win_found_s;
  logic [IDX_W-1:0]       win_idx_s;

  // Per-master views of the packed buses so the owner can be selected by index.
  logic [ADR_WIDTH-1:0] adr_a_s [NUM_MASTERS];
  logic [DAT_WIDTH-1:0] dat_a_s [NUM_MASTERS];
  logic [SEL_WIDTH-1:0] sel_a_s [NUM_MASTERS];

  for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_unpack
    assign adr_a_s[gi] = m_adr[gi*ADR_WIDTH +: ADR_WIDTH];
    assign dat_a_s[gi] = m_dat_m[gi*DAT_WIDTH +: DAT_WIDTH];
    assign sel_a_s[gi] = m_sel[gi*SEL_WIDTH +: SEL_WIDTH];
  end

  // Read data goes to every master; only the owner sees an ack.
  assign m_dat_s = s_dat_s;
  assign gnt     = gnt_r;

  // Round-robin search: first requester strictly after the last owner, wrapping.
  always_comb begin
    win_found_s = 1'b0;
    win_idx_s   = {IDX_W{1'b0}};
    for (int i = 1; i <= NUM_MASTERS; i++) begin
      int cand;
      cand = int'(last_r) + i;
      cand = (cand >= NUM_MASTERS) ? (cand - NUM_MASTERS) : cand;
      if (!win_found_s && m_cyc[cand[IDX_W-1:0]]) begin
        win_found_s = 1'b1;
        win_idx_s   = cand[IDX_W-1:0];
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Next-state, grant, and watchdog count; release of the owner wins over expiry.
  always_comb begin
    state_nxt_s  = state_r;
    gnt_nxt_s    = gnt_r;
    owner_nxt_s  = owner_r;
    last_nxt_s   = last_r;
    wd_cnt_nxt_s = wd_cnt_r;
    case (state_r)
      ST_IDLE: begin
        wd_cnt_nxt_s = {CNT_W{1'b0}};
        if (win_found_s) begin
          state_nxt_s            = ST_BUSY;
          gnt_nxt_s              = {NUM_MASTERS{1'b0}};
          gnt_nxt_s[win_idx_s]   = 1'b1;
          owner_nxt_s            = win_idx_s;
          last_nxt_s             = win_idx_s;
        end else begin
          gnt_nxt_s = {NUM_MASTERS{1'b0}};
        end
      end
      ST_BUSY: begin
        if (!m_cyc[owner_r]) begin
          state_nxt_s  = ST_IDLE;
          gnt_nxt_s    = {NUM_MASTERS{1'b0}};
          wd_cnt_nxt_s = {CNT_W{1'b0}};
        end else if (WD_ON && m_stb[owner_r] && !s_ack) begin
          if (wd_cnt_r == WD_LAST) begin
            state_nxt_s  = ST_ERR;
            wd_cnt_nxt_s = {CNT_W{1'b0}};
          end else begin
            wd_cnt_nxt_s = wd_cnt_r + CNT_W'(1);
          end
        end else begin
          wd_cnt_nxt_s = {CNT_W{1'b0}};
        end
      end
      ST_ERR: begin
        wd_cnt_nxt_s = {CNT_W{1'b0}};
        if (m_cyc[owner_r]) begin
          state_nxt_s = ST_BUSY;
        end else begin
          state_nxt_s = ST_IDLE;
          gnt_nxt_s   = {NUM_MASTERS{1'b0}};
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        gnt_nxt_s    = {NUM_MASTERS{1'b0}};
        wd_cnt_nxt_s = {CNT_W{1'b0}};
      end
    endcase
  end

  // Arbiter state registers; reset hands first priority to master 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      gnt_r    <= {NUM_MASTERS{1'b0}};
      owner_r  <= {IDX_W{1'b0}};
      last_r   <= LAST_RST;
      wd_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      gnt_r    <= gnt_nxt_s;
      owner_r  <= owner_nxt_s;
      last_r   <= last_nxt_s;
      wd_cnt_r <= wd_cnt_nxt_s;
    end
  end

  // Bus steering: owner's signals pass straight through while BUSY, err pulse in ERR.
  always_comb begin
    s_cyc   = 1'b0;
    s_stb   = 1'b0;
    s_we    = 1'b0;
    s_adr   = {ADR_WIDTH{1'b0}};
    s_dat_m = {DAT_WIDTH{1'b0}};
    s_sel   = {SEL_WIDTH{1'b0}};
    m_ack   = {NUM_MASTERS{1'b0}};
    m_err   = {NUM_MASTERS{1'b0}};
    case (state_r)
      ST_BUSY: begin
        s_cyc          = m_cyc[owner_r];
        s_stb          = m_stb[owner_r];
        s_we           = m_we[owner_r];
        s_adr          = adr_a_s[owner_r];
        s_dat_m        = dat_a_s[owner_r];
        s_sel          = sel_a_s[owner_r];
        m_ack[owner_r] = s_ack & m_stb[owner_r];
      end
      ST_ERR: begin
        m_err[owner_r] = 1'b1;
      end
      ST_IDLE: begin
        s_cyc = 1'b0;
      end
      default: begin
        s_cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter: four masters, 32-bit buses, watchdog of
// 8 cycles. Inputs change 1 ns after the rising edge; outputs are checked
// 1 ns after that.
module tb_wb_arbiter;

  localparam int NM = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NM-1:0]   m_cyc, m_stb, m_we;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat_m;
  logic [NM*SW-1:0] m_sel;
  logic [NM-1:0]   m_ack, m_err;
  logic [DW-1:0]   m_dat_s;
  logic            s_cyc, s_stb, s_we;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_m;
  logic [SW-1:0]   s_sel;
  logic            s_ack;
  logic [DW-1:0]   s_dat_s;
  logic [NM-1:0]   gnt;

  int n_checks = 0;
  int n_errors = 0;

  wb_arbiter #(
    .NUM_MASTERS(NM), .ADR_WIDTH(AW), .DAT_WIDTH(DW), .SEL_WIDTH(SW), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_m(m_dat_m), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_dat_s(m_dat_s),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_m(s_dat_m), .s_sel(s_sel),
    .s_ack(s_ack), .s_dat_s(s_dat_s), .gnt(gnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NM-1:0] exp_g;
    rst_n   = 1'b0;
    m_cyc   = 4'b0000; m_stb = 4'b0000; m_we = 4'b0000;
    m_adr   = '0; m_dat_m = '0; m_sel = '0;
    s_ack   = 1'b0; s_dat_s = 32'h0;
    tick(); tick();
    #1;
    check_eq("rst_gnt", 64'(gnt), 64'(4'b0000));
    check_eq("rst_scyc", 64'(s_cyc), 64'(1'b0));
    check_eq("rst_ack_err", 64'({m_ack, m_err}), 64'(8'h00));
    rst_n = 1'b1;

    // single write from master 0
    tick();
    m_cyc = 4'b0001; m_stb = 4'b0001; m_we = 4'b0001;
    m_adr[0*AW +: AW] = 32'h100; m_dat_m[0*DW +: DW] = 32'hDEADBEEF; m_sel[0*SW +: SW] = 4'hF;
    #1;
    check_eq("t1_idle_gnt", 64'(gnt), 64'(4'b0000));
    check_eq("t1_idle_scyc", 64'(s_cyc), 64'(1'b0));
    tick(); #1;
    check_eq("t1_gnt", 64'(gnt), 64'(4'b0001));
    check_eq("t1_sbus", 64'({s_cyc, s_stb, s_we, s_sel}), 64'(7'b111_1111));
    check_eq("t1_adr", 64'(s_adr), 64'(32'h100));
    check_eq("t1_dat", 64'(s_dat_m), 64'(32'hDEADBEEF));
    check_eq("t1_noack", 64'(m_ack), 64'(4'b0000));
    s_ack = 1'b1; s_dat_s = 32'h12345678;
    #1;
    check_eq("t1_ack", 64'(m_ack), 64'(4'b0001));
    check_eq("t1_rdat", 64'(m_dat_s), 64'(32'h12345678));
    tick();
    s_ack = 1'b0; m_cyc = 4'b0000; m_stb = 4'b0000; m_we = 4'b0000;
    tick(); #1;
    check_eq("t1_release", 64'(gnt), 64'(4'b0000));

    // fresh reset, then masters 0 and 1 alternate
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0010;
      m_cyc = 4'b0011; m_stb = 4'b0011;
      tick(); #1;
      check_eq($sformatf("t2_gnt%0d", k), 64'(gnt), 64'(exp_g));
      s_ack = 1'b1;
      #1;
      check_eq($sformatf("t2_ack%0d", k), 64'(m_ack), 64'(exp_g));
      tick();
      s_ack = 1'b0; m_cyc = 4'b0011 & ~exp_g; m_stb = 4'b0011 & ~exp_g;
      tick(); #1;
      check_eq($sformatf("t2_idle%0d", k), 64'(gnt), 64'(4'b0000));
    end

    // master 2 burst of four reads while master 1 waits (last owner was 1)
    m_cyc = 4'b0110; m_stb = 4'b0000;
    tick(); #1;
    check_eq("t3_gnt", 64'(gnt), 64'(4'b0100));
    for (int b = 0; b < 4; b++) begin
      m_stb = 4'b0100; m_adr[2*AW +: AW] = 32'h10 + 32'(4 * b);
      s_ack = 1'b1;
      #1;
      check_eq($sformatf("t3_adr%0d", b), 64'(s_adr), 64'(32'h10 + 32'(4 * b)));
      check_eq($sformatf("t3_ack%0d", b), 64'({gnt, m_ack}), 64'({4'b0100, 4'b0100}));
      tick();
    end
    s_ack = 1'b0; m_stb = 4'b0000; m_cyc = 4'b0010;
    tick(); #1;
    check_eq("t3_idle", 64'(gnt), 64'(4'b0000));
    tick(); #1;
    check_eq("t3_m1_gnt", 64'(gnt), 64'(4'b0010));
    m_cyc = 4'b0000;
    tick(); #1;

    // watchdog: master 3 strobes, slave never acks
    m_cyc = 4'b1000; m_stb = 4'b1000;
    tick(); #1;
    check_eq("t4_gnt", 64'(gnt), 64'(4'b1000));
    check_eq("t4_stb", 64'(s_stb), 64'(1'b1));
    for (int c = 1; c < 8; c++) begin
      tick(); #1;
      check_eq($sformatf("t4_wait%0d", c), 64'({m_err, s_cyc}), 64'({4'b0000, 1'b1}));
    end
    tick();
    s_ack = 1'b1;
    #1;
    check_eq("t4_err", 64'(m_err), 64'(4'b1000));
    check_eq("t4_err_bus", 64'({s_cyc, s_stb}), 64'(2'b00));
    check_eq("t4_err_noack", 64'(m_ack), 64'(4'b0000));
    s_ack = 1'b0; m_cyc = 4'b0000; m_stb = 4'b0000;
    tick(); #1;
    check_eq("t4_after", 64'({gnt, m_err}), 64'(8'h00));

    // reset mid-strobe; master 0 owns, afterwards master 0 wins again
    m_cyc = 4'b0001; m_stb = 4'b0001;
    tick(); #1;
    check_eq("t5_gnt", 64'(gnt), 64'(4'b0001));
    s_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_out", 64'({s_cyc, s_stb, gnt, m_ack}), 64'(10'b0));
    tick();
    rst_n = 1'b1; s_ack = 1'b0; m_cyc = 4'b0011; m_stb = 4'b0000;
    tick(); #1;
    check_eq("t5_restart", 64'(gnt), 64'(4'b0001));

    // cyc without stb: held past the watchdog length, no ack/err
    for (int c = 0; c < 10; c++) begin
      check_eq($sformatf("t6_hold%0d", c), 64'({s_cyc, s_stb, m_ack, m_err}), 64'({1'b1, 1'b0, 8'h00}));
      tick(); #1;
    end
    m_cyc = 4'b0010;
    tick(); #1;
    check_eq("t6_release", 64'(gnt), 64'(4'b0000));
    tick(); #1;
    check_eq("t6_next", 64'({gnt, s_stb}), 64'({4'b0010, 1'b0}));
    m_cyc = 4'b0000;
    tick(); #1;
    check_eq("t6_idle", 64'(gnt), 64'(4'b0000));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
- Round-robin arbiter that shares one standard-mode (classic, non-pipelined) Wishbone slave between NUM_MASTERS masters.
- Grant is registered and held for the whole bus cycle (m_cyc high), so block and RMW cycles stay atomic.
- Optional watchdog terminates an unacknowledged strobe with a one-cycle err pulse to the owning master.
- Sits between the masters' interconnect ports and a single slave; the slave sees a stall-free classic bus.

Parameters:
- NUM_MASTERS, 4, number of requesting masters (2..16).
- ADR_WIDTH, 32, address width.
- DAT_WIDTH, 32, data width (multiple of 8).
- SEL_WIDTH, DAT_WIDTH/8, byte-select width.
- TIMEOUT, 0, cycles of stb without ack before abort; 0 disables the watchdog.

Ports:
- clk  in  1  bus clock, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- m_cyc  in  NUM_MASTERS  per-master cycle request.
- m_stb  in  NUM_MASTERS  per-master strobe.
- m_we  in  NUM_MASTERS  per-master write enable.
- m_adr  in  NUM_MASTERS*ADR_WIDTH  packed addresses, master i at slice i.
- m_dat_m  in  NUM_MASTERS*DAT_WIDTH  packed write data.
- m_sel  in  NUM_MASTERS*SEL_WIDTH  packed byte selects.
- m_ack  out  NUM_MASTERS  per-master acknowledge.
- m_err  out  NUM_MASTERS  per-master timeout error.
- m_dat_s  out  DAT_WIDTH  read data, broadcast to all masters.
- s_cyc, s_stb, s_we  out  1 each  to slave.
- s_adr  out  ADR_WIDTH  to slave.
- s_dat_m  out  DAT_WIDTH  to slave.
- s_sel  out  SEL_WIDTH  to slave.
- s_ack  in  1  from slave.
- s_dat_s  in  DAT_WIDTH  from slave.
- gnt  out  NUM_MASTERS  registered one-hot grant; all zero when idle.

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE, gnt=0, last=NUM_MASTERS-1 (master 0 has first priority), watchdog count=0.
  - All s_* outputs, m_ack and m_err are 0.
- IDLE:
  - s_cyc/s_stb/s_we/s_adr/s_dat_m/s_sel driven to 0.
  - If any m_cyc is high, select the first requester searching upward from last+1, wrapping modulo NUM_MASTERS.
  - Next cycle: gnt = one-hot of the winner, last = winner, state=BUSY. Arbitration latency is exactly 1 cycle.
- BUSY (owner g):
  - s_cyc = m_cyc[g], s_stb = m_stb[g]; s_we/s_adr/s_dat_m/s_sel muxed from slice g. Combinational, no added latency.
  - m_ack[g] = s_ack & m_stb[g]; all other m_ack bits are 0. m_dat_s = s_dat_s at all times.
  - Requests from other masters are ignored; their m_ack and m_err stay 0.
  - When m_cyc[g] is sampled low: next state=IDLE, gnt=0. There is at least one idle cycle between owners.
- Watchdog (TIMEOUT>0, BUSY only):
  - Count increments each cycle with s_stb=1 and s_ack=0; cleared on s_ack, on s_stb=0, and on leaving BUSY.
  - When count reaches TIMEOUT-1 with no ack that cycle: next state=ERR.
- ERR (one cycle, owner g):
  - s_cyc=s_stb=0, m_err[g]=1, m_ack=0; any s_ack this cycle is dropped.
  - Next: BUSY with the same owner if m_cyc[g]=1, else IDLE. Count is cleared.
  - The owner must drop stb or re-present the request after err.
- m_ack and m_err are never both high for a master in the same cycle.
- Simultaneous events:
  - Owner release and new requests in the same cycle: release wins; the new requests are arbitrated in the following IDLE cycle.
  - Owner drops m_cyc in the same cycle the watchdog expires: go to IDLE, no err.
- Reset mid-transfer: all outputs go to 0 immediately (async); the next arbitration restarts from master 0.
- Round-robin fairness: with all masters continuously requesting, each master is granted once per NUM_MASTERS bus cycles.

Test Plan:
- Reset release; m_cyc=0001, m_stb[0]=1, we=1, adr=0x100, dat=0xDEADBEEF -> gnt=0001 one cycle later; s_adr=0x100, s_dat_m=0xDEADBEEF; slave ack -> m_ack=0001 in the same cycle.
- m_cyc=0011 held continuously, each master doing one single access and then dropping cyc -> grant order 0,1,0,1, with an idle cycle (gnt=0000) between grants.
- Master 2 holds cyc across 4 strobes (burst of reads 0x10..0x1C) while master 1 requests -> gnt stays 0100 for all 4 acks; master 1 is granted only after master 2 drops cyc.
- TIMEOUT=8; slave never acks -> m_err[g] high exactly 8 cycles after stb rises; s_cyc=0 in that cycle; m_ack stays 0.
- Reset asserted while BUSY mid-strobe -> s_cyc, s_stb, gnt, m_ack all 0 in the same cycle; after release, master 0 wins even if last owner was 3.
- Master raises cyc without stb, then drops it -> grant given then released; slave sees s_stb=0 throughout; no ack or err generated.
